sar_adc_ctrl: RTL and testbench



---
 rtl/sar_adc_ctrl.sv | 125 ++++++++++++
 tb/tb_sar_adc_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller driving an R2R trial DAC and
// reading an external comparator through a 2-flop synchronizer.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_out,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] sample
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [WIDTH-1:0] MSB      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0]    BIT_TOP  = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DECIDE,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] trial, trial_n;
    logic [BW-1:0]    bidx, bidx_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [1:0]       sync;
    logic             cmp_s;

    assign cmp_s = sync[1];

    // Two-flop synchronizer for the asynchronous comparator output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], cmp_in};
        end
    end

    // Next-state logic: binary search over the trial code, one bit per DECIDE
    always_comb begin
        state_n = state;
        trial_n = trial;
        bidx_n  = bidx;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (start || cont) begin
                    state_n = SETTLE;
                    trial_n = MSB;
                    bidx_n  = BIT_TOP;
                    cnt_n   = '0;
                end
            end
            SETTLE: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_n = DECIDE;
                end
            end
            DECIDE: begin
                if (!cmp_s) begin
                    trial_n[bidx] = 1'b0;
                end
                if (bidx != '0) begin
                    trial_n[bidx - 1'b1] = 1'b1;
                    bidx_n  = bidx - 1'b1;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (cont) begin
                    state_n = SETTLE;
                    trial_n = MSB;
                    bidx_n  = BIT_TOP;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register plus registered outputs derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            trial   <= '0;
            bidx    <= BIT_TOP;
            cnt     <= '0;
            dac_out <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            sample  <= '0;
        end else begin
            state   <= state_n;
            trial   <= trial_n;
            bidx    <= bidx_n;
            cnt     <= cnt_n;
            dac_out <= (state_n == IDLE) ? '0 : trial_n;
            busy    <= (state_n == SETTLE) || (state_n == DECIDE);
            valid   <= (state_n == DONE);
            if (state_n == DONE) begin
                sample <= trial_n;
            end
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: ideal comparator model, scheduled
// stimulus per cycle, and arithmetic expectations of the binary search.
module tb_sar_adc_ctrl;

    localparam int W   = 8;
    localparam int S   = 4;
    localparam int LAT = W * (S + 1) + 1;
    localparam int N   = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         cont;
    logic         cmp_in;
    logic [W-1:0] dac_out;
    logic         busy;
    logic         valid;
    logic [W-1:0] sample;

    logic         f_en;
    logic         f_val;
    logic [W-1:0] vin;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] dac_h [0:N-1];
    logic         busy_h[0:N-1];
    logic         val_h [0:N-1];
    logic [W-1:0] smp_h [0:N-1];

    logic         st_s[0:N-1];
    logic         ct_s[0:N-1];
    logic         fe_s[0:N-1];
    logic         fv_s[0:N-1];
    logic [W-1:0] v_s [0:N-1];

    sar_adc_ctrl #(
        .WIDTH(W),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cont(cont),
        .cmp_in(cmp_in),
        .dac_out(dac_out),
        .busy(busy),
        .valid(valid),
        .sample(sample)
    );

    always #5 clk = ~clk;

    // Ideal comparator: Vin >= Vdac, optionally overridden
    assign cmp_in = f_en ? f_val : (vin >= dac_out);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_sched(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) begin
            st_s[i] = 1'b0;
            ct_s[i] = 1'b0;
            fe_s[i] = 1'b0;
            fv_s[i] = 1'b0;
            v_s[i]  = v;
        end
    endtask

    task automatic apply(input int c);
        start = st_s[c];
        cont  = ct_s[c];
        f_en  = fe_s[c];
        f_val = fv_s[c];
        vin   = v_s[c];
    endtask

    // Caller sits 1 time unit after a rising edge: that is cycle 0
    task automatic run(input int n);
        apply(0);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            dac_h[c]  = dac_out;
            busy_h[c] = busy;
            val_h[c]  = valid;
            smp_h[c]  = sample;
            apply(c);
        end
    endtask

    function automatic int nvalid(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (val_h[c]) n++;
        return n;
    endfunction

    function automatic int first_valid(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) if (val_h[c]) return c;
        return -1;
    endfunction

    function automatic int nbusy(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (busy_h[c]) n++;
        return n;
    endfunction

    // Trial k keeps the top k bits of V and sets the next bit down
    function automatic int exp_trial(input int v, input int k);
        int top;
        top = (v >> (W - k)) << (W - k);
        return top | (1 << (W - 1 - k));
    endfunction

    task automatic check_conv(input string tag, input int c0,
                              input logic [W-1:0] v);
        chk({tag, ".vcyc"}, first_valid(c0 + 1, c0 + LAT), c0 + LAT);
        chk({tag, ".smp"}, smp_h[c0 + LAT], v);
        for (int k = 0; k < W; k++) begin
            chk($sformatf("%s.dac%0d", tag, k),
                dac_h[c0 + 1 + k * (S + 1)], exp_trial(v, k));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] edges[4];
        edges = '{8'h00, 8'hFF, 8'h80, 8'h7F};

        rst = 1'b1;
        clear_sched(8'h00);
        apply(0);
        @(posedge clk);
        #1;
        chk("rst.dac", dac_out, 0);
        chk("rst.busy", busy, 0);
        chk("rst.valid", valid, 0);
        chk("rst.smp", sample, 0);
        rst = 1'b0;

        // Basic conversion with full waveform checks
        clear_sched(8'hA5);
        st_s[0] = 1'b1;
        run(45);
        check_conv("t1", 0, 8'hA5);
        chk("t1.nval", nvalid(1, 45), 1);
        chk("t1.busy", nbusy(1, 40), 40);
        chk("t1.busy41", busy_h[41], 0);
        chk("t1.dacend", dac_h[41], 8'hA5);
        chk("t1.idle", dac_h[42], 0);
        chk("t1.hold", smp_h[45], 8'hA5);

        // Endpoints then random inputs
        for (int i = 0; i < 10; i++) begin
            v = (i < 4) ? edges[i] : W'($urandom_range(0, 255));
            clear_sched(v);
            st_s[0] = 1'b1;
            run(42);
            check_conv($sformatf("t2_%0d", i), 0, v);
            chk($sformatf("t2_%0d.dacend", i), dac_h[41], v);
        end

        // Start while busy is ignored
        v = W'($urandom_range(1, 255));
        clear_sched(v);
        st_s[0]  = 1'b1;
        st_s[20] = 1'b1;
        run(60);
        chk("t3.nval", nvalid(1, 60), 1);
        chk("t3.vcyc", first_valid(1, 60), 41);
        chk("t3.busy", nbusy(1, 40), 40);
        chk("t3.smp", smp_h[41], v);

        // Asynchronous reset mid-conversion
        clear_sched(8'h5A);
        st_s[0] = 1'b1;
        run(15);
        #3;
        rst = 1'b1;
        #1;
        chk("t4.dac", dac_out, 0);
        chk("t4.busy", busy, 0);
        chk("t4.valid", valid, 0);
        chk("t4.smp", sample, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_sched(8'h3C);
        st_s[0] = 1'b1;
        run(42);
        check_conv("t4", 0, 8'h3C);

        // Continuous mode, input moves between conversions, cont dropped
        clear_sched(8'h10);
        for (int c = 0; c < 100; c++) ct_s[c] = 1'b1;
        for (int c = 41; c < N; c++) v_s[c] = 8'hE0;
        run(140);
        check_conv("t5a", 0, 8'h10);
        check_conv("t5b", 41, 8'hE0);
        chk("t5c.vcyc", first_valid(83, 130), 123);
        chk("t5c.smp", smp_h[123], 8'hE0);
        chk("t5.nval", nvalid(1, 140), 3);
        chk("t5.idle_dac", dac_h[130], 0);
        chk("t5.idle_busy", busy_h[130], 0);

        // Synchronizer: DECIDE of bit 7 (cycle 5) sees cycle-3 cmp_in
        clear_sched(8'h00);
        st_s[0] = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            fe_s[c] = 1'b1;
            fv_s[c] = (c <= 3);
        end
        run(42);
        chk("t6a.smp", smp_h[41], 8'h80);

        clear_sched(8'hFF);
        st_s[0] = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            fe_s[c] = 1'b1;
            fv_s[c] = (c == 4);
        end
        run(42);
        chk("t6b.smp", smp_h[41], 8'h7F);

        clear_sched(8'h00);
        st_s[0] = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            fe_s[c] = 1'b1;
            fv_s[c] = (c <= 2);
        end
        run(42);
        chk("t6c.smp", smp_h[41], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
